// File: rtl/seven_seg_scan.sv
// seven_seg_scan: drives a 4-digit common-anode seven-segment display.
// The four BCD digits are time-multiplexed onto one shared cathode bus.
// The block also provides:
//   - frame-synchronous capture of all inputs,
//   - leading-zero blanking,
//   - per-digit blinking,
//   - per-digit decimal points,
//   - a dash for invalid (non-BCD) codes.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   dig1000..dig1       thousands/hundreds/tens/ones BCD digits
//   lz_blank            1 = suppress leading zeros
//   blink_mask[3:0]     per-digit blink enable, bit i = an[i]
//   dp_mask[3:0]        per-digit decimal point request, bit i = an[i]
//   an[3:0]             anode enables, active-low
//   seg[6:0]            cathodes {g,f,e,d,c,b,a}, active-low
//   dp                  decimal point cathode, active-low
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig1000,
  input  logic [3:0] dig100,
  input  logic [3:0] dig10,
  input  logic [3:0] dig1,
  input  logic       lz_blank,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned TW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0] tick_cnt;
  logic [1:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          valid;

  logic [3:0] d1000_snap, d100_snap, d10_snap, d1_snap;
  logic       lz_snap;
  logic [3:0] blink_snap, dp_snap;

  logic       tick, frame_end, capture;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] cur_digit;
  logic       blank_lz, blank;

  // The scan is held until valid. The first shown digit then gets a full
  // REFRESH_DIV cycles, with the same latency after every reset.
  assign tick      = valid && (tick_cnt == TICK_LAST);
  assign frame_end = tick && (idx == 2'd3);
  assign capture   = !valid || frame_end;

  always_comb begin
    cur_digit = d1_snap;
    blank_lz  = 1'b0;
    case (idx)
      2'd0: cur_digit = d1_snap;
      2'd1: begin
        cur_digit = d10_snap;
        blank_lz  = lz_snap && (d1000_snap == '0) && (d100_snap == '0) && (d10_snap == '0);
      end
      2'd2: begin
        cur_digit = d100_snap;
        blank_lz  = lz_snap && (d1000_snap == '0) && (d100_snap == '0);
      end
      default: begin
        cur_digit = d1000_snap;
        blank_lz  = lz_snap && (d1000_snap == '0);
      end
    endcase
    blank = !valid || blank_lz || (blink_phase && blink_snap[idx]);

    case (cur_digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase
    an_d = ~(4'b0001 << idx);
    dp_d = ~dp_snap[idx];

    if (blank) begin
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      valid       <= 1'b0;
      d1000_snap  <= '0;
      d100_snap   <= '0;
      d10_snap    <= '0;
      d1_snap     <= '0;
      lz_snap     <= 1'b0;
      blink_snap  <= '0;
      dp_snap     <= '0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
    end else begin
      valid <= 1'b1;
      if (valid)
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick)
        idx <= idx + 2'd1;
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
      if (capture) begin
        d1000_snap <= dig1000;
        d100_snap  <= dig100;
        d10_snap   <= dig10;
        d1_snap    <= dig1;
        lz_snap    <= lz_blank;
        blink_snap <= blink_mask;
        dp_snap    <= dp_mask;
      end
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
